multicycle_control: RTL
=======================

# multicycle_control

Multicycle main control unit for the MIPS-subset datapath: an opcode-driven FSM that sequences fetch, decode, execute, memory and write-back over several cycles. It replaces purely combinational opcode decoding so that the ALU and a single shared instruction/data memory are reused across cycles. Memory accesses use a ready handshake with a bounded wait-state counter. It adds `addi` and an illegal-opcode trap to the R-format/`lw`/`sw`/`beq`/`jalpc` set.

## Interface
- `OP_LW`, default 6'b100011: load opcode
- `OP_SW`, default 6'b101011: store opcode
- `OP_BEQ`, default 6'b000100: branch-equal opcode
- `OP_ADDI`, default 6'b001000: add-immediate opcode
- `OP_JALPC`, default 6'b011111: jalpc opcode
- `WAIT_LIMIT`, default 15: maximum wait cycles per memory access; 0 disables the timeout
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `in` in 6: opcode `IR[31:26]`, valid from DECODE onward
- `mem_ready` in 1: memory completes the current access this cycle
- `pcwrite`, `pcwritecond` out 1 each: PC write enables (`pcwritecond` is ANDed with zero in the datapath)
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut
- `memread`, `memwrite` out 1 each: memory strobes
- `irwrite` out 1: instruction register load
- `regdest` out 1: destination register select, 1 = rd, 0 = rt
- `regwrite` out 1: register file write enable
- `wdsel` out 2: write-data select, 0 = ALUOut, 1 = MDR, 2 = PC
- `alusrca` out 1: ALU A select, 0 = PC, 1 = A
- `alusrcb` out 2: ALU B select, 0 = B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm << 2
- `aluop` out 2: ALU op, 00 = add, 01 = sub, 10 = funct
- `pcsource` out 2: PC source, 0 = ALU, 1 = ALUOut, 2 = jump target
- `instr_done` out 1: pulse in the final cycle of each instruction
- `illegal` out 1: pulse on an undecodable opcode
- `bus_error` out 1: pulse on a memory wait timeout
- `state` out 4: current state, for debug

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JALPC 9, IEXEC 10, IWB 11. Codes 12–15 are unreachable and recover to FETCH.
- Outputs are decoded from `state`. Any output not listed for a state is 0.
- **FETCH**
  - Asserts `memread`, `iord`=0, `alusrca`=0, `alusrcb`=1, `aluop`=00, `pcsource`=0.
  - `irwrite` and `pcwrite` are asserted only when `mem_ready`=1 (Mealy).
  - Moves to DECODE on `mem_ready`, otherwise stays in FETCH.
- **DECODE**
  - Drives `alusrca`=0, `alusrcb`=3, `aluop`=00 (branch target).
  - R-format (`in`==0) → EXEC.
  - `lw` or `sw` → MEMADR.
  - `beq` → BRANCH.
  - `addi` → IEXEC.
  - `jalpc` → JALPC.
  - Any other opcode: `illegal`=1 and `instr_done`=1 this cycle, then → FETCH.
- **MEMADR:** `alusrca`=1, `alusrcb`=2, `aluop`=00. Goes to MEMRD for `lw`, MEMWR for `sw`.
- **MEMRD:** `memread`, `iord`=1. Goes to MEMWB on `mem_ready`.
- **MEMWB:** `regwrite`, `regdest`=0, `wdsel`=1, `instr_done`. Then → FETCH.
- **MEMWR:** `memwrite`, `iord`=1. On `mem_ready`, asserts `instr_done` and goes to FETCH.
- **EXEC:** `alusrca`=1, `alusrcb`=0, `aluop`=10. Then → RWB.
- **RWB:** `regwrite`, `regdest`=1, `wdsel`=0, `instr_done`. Then → FETCH.
- **BRANCH:** `alusrca`=1, `alusrcb`=0, `aluop`=01, `pcwritecond`, `pcsource`=1, `instr_done`. Then → FETCH.
- **IEXEC:** `alusrca`=1, `alusrcb`=2, `aluop`=00. Then → IWB.
- **IWB:** `regwrite`, `regdest`=0, `wdsel`=0, `instr_done`. Then → FETCH.
- **JALPC:** `regwrite`, `regdest`=0, `wdsel`=2, `pcwrite`, `pcsource`=2, `instr_done`. Then → FETCH.
- **Wait counter**
  - Counts cycles spent in FETCH, MEMRD or MEMWR with `mem_ready`=0.
  - Clears on entering any state.
  - With `WAIT_LIMIT`>0: when the counter reaches `WAIT_LIMIT` and `mem_ready`=0, pulse `bus_error` and go to FETCH. All memory strobes and enables are deasserted that cycle.
  - A timeout while already in FETCH restarts the fetch.

## Timing
- **Reset**
  - While `reset`=1, every output is 0 and `state` is 0.
  - On the first edge with `reset`=1, `state`=FETCH and the wait counter is cleared.
  - Reset mid-instruction aborts the instruction; no write enable is asserted in the reset cycle.
- **Zero-wait latencies** (`mem_ready` held at 1), in cycles:
  - R-format: 4
  - `lw`: 5
  - `sw`: 4
  - `beq`: 3
  - `addi`: 4
  - `jalpc`: 3
  - illegal opcode: 2
- Each memory wait cycle adds 1 to the latency.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.
- `mem_ready`=1 and a timeout in the same cycle: `mem_ready` wins.
- `instr_done`, `illegal` and `bus_error` are single-cycle pulses.

## Test plan
- **Reset:** assert `reset` for 2 cycles mid-MEMRD → all outputs 0, then `state`=0; FETCH asserts `memread` on the next cycle.
- **R-format then `lw`:** `in`=0 then `in`=6'b100011, `mem_ready`=1 → state sequence 0,1,6,7 then 0,1,2,3,4; `regwrite` with `regdest`=1 at RWB, `regwrite` with `wdsel`=1 at MEMWB.
- **`sw` with wait:** `sw` with `mem_ready` low 3 cycles in MEMWR → `memwrite` high 4 cycles; `instr_done` on the 4th.
- **`beq` and `jalpc`:** `beq` → `pcwritecond`=1, `pcsource`=1, `aluop`=01 in state 8; `jalpc` → `regwrite`, `wdsel`=2, `pcwrite`, `pcsource`=2 in state 9.
- **Illegal opcode:** `in`=6'b111111 → `illegal` pulse in DECODE, FETCH next cycle, no `regwrite` or `memwrite`.
- **Timeout:** `WAIT_LIMIT`=4 with `mem_ready` held 0 in MEMRD → `bus_error` pulse, → FETCH. Second case: `mem_ready` rises in the limit cycle → no `bus_error`, → MEMWB.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle main control FSM for the MIPS-subset datapath: sequences
// fetch/decode/execute/memory/write-back with a ready-handshake memory.
// Ports: clk, reset (sync, active-high); in = IR[31:26]; mem_ready = memory
// completes this cycle. Outputs: datapath enables/selects (pcwrite,
// pcwritecond, iord, memread, memwrite, irwrite, regdest, regwrite, wdsel,
// alusrca, alusrcb, aluop, pcsource), status pulses (instr_done, illegal,
// bus_error) and the current state for debug.
module multicycle_control #(
    parameter logic [5:0] OP_LW      = 6'b100011,
    parameter logic [5:0] OP_SW      = 6'b101011,
    parameter logic [5:0] OP_BEQ     = 6'b000100,
    parameter logic [5:0] OP_ADDI    = 6'b001000,
    parameter logic [5:0] OP_JALPC   = 6'b011111,
    parameter int         WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] in,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdest,
    output logic       regwrite,
    output logic [1:0] wdsel,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsource,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_error,
    output logic [3:0] state
);

    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JALPC  = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regdest;
        logic       regwrite;
        logic [1:0] wdsel;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       instr_done;
        logic       illegal;
        logic       bus_error;
    } ctl_t;

    state_t        cur;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic          mem_state;
    logic          timeout;
    ctl_t          c;

    // Only the three memory-facing states ever wait on mem_ready.
    assign mem_state = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);

    // A ready response in the limit cycle beats the timeout.
    assign timeout = (WAIT_LIMIT != 0) && mem_state && !mem_ready
                     && (cnt == CW'(WAIT_LIMIT));

    always_ff @(posedge clk) begin
        if (reset)
            cur <= S_FETCH;
        else
            cur <= nxt;
    end

    // Cleared on every state entry, including a timeout re-entering FETCH.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (nxt != cur || timeout)
            cnt <= '0;
        else if (mem_state && !mem_ready && cnt != CW'(WAIT_LIMIT))
            cnt <= cnt + 1'b1;
    end

    always_comb begin
        c   = '0;
        nxt = cur;
        case (cur)
            S_FETCH: begin
                c.memread = 1'b1;
                c.alusrcb = 2'd1;
                if (mem_ready) begin
                    c.irwrite = 1'b1;
                    c.pcwrite = 1'b1;
                    nxt       = S_DECODE;
                end
            end
            S_DECODE: begin
                c.alusrcb = 2'd3;
                unique case (1'b1)
                    (in == 6'd0):                 nxt = S_EXEC;
                    (in == OP_LW || in == OP_SW): nxt = S_MEMADR;
                    (in == OP_BEQ):               nxt = S_BRANCH;
                    (in == OP_ADDI):              nxt = S_IEXEC;
                    (in == OP_JALPC):             nxt = S_JALPC;
                    default: begin
                        c.illegal    = 1'b1;
                        c.instr_done = 1'b1;
                        nxt          = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'd2;
                nxt       = (in == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
                if (mem_ready) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                c.regwrite   = 1'b1;
                c.wdsel      = 2'd1;
                c.instr_done = 1'b1;
                nxt          = S_FETCH;
            end
            S_MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
                if (mem_ready) begin
                    c.instr_done = 1'b1;
                    nxt          = S_FETCH;
                end
            end
            S_EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
                nxt       = S_RWB;
            end
            S_RWB: begin
                c.regwrite   = 1'b1;
                c.regdest    = 1'b1;
                c.instr_done = 1'b1;
                nxt          = S_FETCH;
            end
            S_BRANCH: begin
                c.alusrca     = 1'b1;
                c.aluop       = 2'b01;
                c.pcwritecond = 1'b1;
                c.pcsource    = 2'd1;
                c.instr_done  = 1'b1;
                nxt           = S_FETCH;
            end
            S_IEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'd2;
                nxt       = S_IWB;
            end
            S_IWB: begin
                c.regwrite   = 1'b1;
                c.instr_done = 1'b1;
                nxt          = S_FETCH;
            end
            S_JALPC: begin
                c.regwrite   = 1'b1;
                c.wdsel      = 2'd2;
                c.pcwrite    = 1'b1;
                c.pcsource   = 2'd2;
                c.instr_done = 1'b1;
                nxt          = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
        if (timeout) begin
            c           = '0;
            c.bus_error = 1'b1;
            nxt         = S_FETCH;
        end
        // Nothing may be enabled while reset is held, whatever the state.
        if (reset) c = '0;
    end

    assign pcwrite     = c.pcwrite;
    assign pcwritecond = c.pcwritecond;
    assign iord        = c.iord;
    assign memread     = c.memread;
    assign memwrite    = c.memwrite;
    assign irwrite     = c.irwrite;
    assign regdest     = c.regdest;
    assign regwrite    = c.regwrite;
    assign wdsel       = c.wdsel;
    assign alusrca     = c.alusrca;
    assign alusrcb     = c.alusrcb;
    assign aluop       = c.aluop;
    assign pcsource    = c.pcsource;
    assign instr_done  = c.instr_done;
    assign illegal     = c.illegal;
    assign bus_error   = c.bus_error;
    assign state       = reset ? 4'd0 : cur;

endmodule
